// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t  - receive FSM state encoding
//   PARITY_*         - values accepted by the PARITY_MODE parameter
//   OVERSAMPLE       - oversample ticks per bit
//   MID_SAMPLE       - ticks from the start edge to the start-bit centre
//   parity_expected  - parity bit that a correct frame carries for a byte
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // Odd parity: data plus parity bit holds an odd number of ones.
  function automatic logic parity_expected(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   i_clk     - clock, rising edge
//   i_rst     - synchronous active-high reset (pointers only)
//   i_push    - write request for i_data
//   i_data    - write data
//   i_pop     - remove head; ignored while empty
//   o_data    - head entry, zero while empty
//   o_empty   - no entries
//   o_full    - DEPTH entries
//   o_push_ok - the current push request is accepted this cycle
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = i_pop && !w_empty;
  // When full, a simultaneous pop frees the head slot that the push then reuses.
  assign w_push = i_push && (!w_full || i_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_push_ok = w_push;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 16x oversampled, 8 data bits, optional parity, 1 stop.
//   clk_in      - system clock, rising edge
//   rst_in      - synchronous active-high reset
//   rx          - asynchronous serial line, idles high
//   rd_en       - pop the FIFO head; ignored while rx_empty
//   rd_data     - FIFO head, valid while !rx_empty
//   rx_empty    - receive FIFO empty
//   rx_full     - receive FIFO full
//   err_frame   - sticky: stop bit sampled low
//   err_parity  - sticky: parity mismatch
//   err_overrun - sticky: good byte dropped on a full FIFO
//   err_clr     - clear the sticky flags; a same-cycle error wins
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       err_frame,
  output logic       err_parity,
  output logic       err_overrun,
  input  logic       err_clr
);

  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rxs_prev;
  logic [1:0]       r_warm;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_par_err;
  logic             r_err_frame;
  logic             r_err_parity;
  logic             r_err_overrun;

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;

  logic       w_rxs;
  logic       w_armed;
  logic       w_tick;
  logic       w_mid_done;
  logic       w_bit_done;
  logic       w_start_edge;
  logic       w_smp_start;
  logic       w_smp_data;
  logic       w_smp_par;
  logic       w_smp_stop;
  logic       w_cnt_wrap;
  logic       w_push_req;
  logic       w_set_frame;
  logic       w_set_parity;
  logic       w_set_overrun;
  logic       w_push_ok;
  logic [7:0] w_fifo_data;
  logic       w_fifo_empty;
  logic       w_fifo_full;

  // Stage 0: two-flop synchroniser; only the second flop feeds the decoder.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_rxs_prev <= r_sync2;
    end
  end

  assign w_rxs = r_sync2;

  // The synchroniser reset value is a fake "high"; edge detection waits until
  // both flops and the previous-sample flop hold real line samples, so a frame
  // already low on the line at reset release is not mistaken for a start edge.
  always_ff @(posedge clk_in) begin
    if (rst_in)              r_warm <= 2'd0;
    else if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
  end

  assign w_armed      = (r_warm == 2'd3);
  assign w_start_edge = (r_state == ST_IDLE) && w_armed && r_rxs_prev && !w_rxs;

  // Oversample divider, restarted on the start edge so ticks align to the frame.
  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in)            r_div_cnt <= '0;
    else if (w_start_edge) r_div_cnt <= '0;
    else if (w_tick)       r_div_cnt <= '0;
    else                   r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  assign w_mid_done = w_tick && (r_tick_cnt == 4'(MID_SAMPLE - 1));
  assign w_bit_done = w_tick && (r_tick_cnt == 4'(OVERSAMPLE - 1));

  // FSM process 1: state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM process 2: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start_edge) w_state_nxt = ST_START;
      ST_START:  if (w_mid_done) w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_bit_done && (r_bit_idx == 3'd7))
                   w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_done) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_bit_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM process 3: sample strobes and frame outcome.
  always_comb begin
    w_smp_start   = (r_state == ST_START)  && w_mid_done;
    w_smp_data    = (r_state == ST_DATA)   && w_bit_done;
    w_smp_par     = (r_state == ST_PARITY) && w_bit_done;
    w_smp_stop    = (r_state == ST_STOP)   && w_bit_done;
    w_cnt_wrap    = w_smp_start || w_smp_data || w_smp_par || w_smp_stop;
    w_push_req    = w_smp_stop && w_rxs && !r_par_err;
    w_set_frame   = w_smp_stop && !w_rxs;
    w_set_parity  = w_smp_stop && w_rxs && r_par_err;
    w_set_overrun = w_push_req && !w_push_ok;
  end

  // Stage 1: sub-bit tick counter, bit index, shift register, parity check.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_par_err  <= 1'b0;
    end else begin
      if (w_start_edge)
        r_tick_cnt <= 4'd0;
      else if ((r_state != ST_IDLE) && w_tick)
        r_tick_cnt <= w_cnt_wrap ? 4'd0 : r_tick_cnt + 4'd1;

      if (w_smp_start)     r_bit_idx <= 3'd0;
      else if (w_smp_data) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_start_edge)   r_par_err <= 1'b0;
      else if (w_smp_par) r_par_err <= (w_rxs != parity_expected(r_shift, PARITY_MODE));
    end
  end

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_ff @(posedge clk_in) begin
    if (w_smp_data) r_shift <= {w_rxs, r_shift[7:1]};
  end

  // Stage 2: sticky error flags; a new error outranks a same-cycle clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err_frame   <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_set_frame)   r_err_frame   <= 1'b1;
      else if (err_clr)  r_err_frame   <= 1'b0;
      if (w_set_parity)  r_err_parity  <= 1'b1;
      else if (err_clr)  r_err_parity  <= 1'b0;
      if (w_set_overrun) r_err_overrun <= 1'b1;
      else if (err_clr)  r_err_overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_push    (w_push_req),
    .i_data    (r_shift),
    .i_pop     (rd_en),
    .o_data    (w_fifo_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_push_ok (w_push_ok)
  );

  assign rd_data     = w_fifo_data;
  assign rx_empty    = w_fifo_empty;
  assign rx_full     = w_fifo_full;
  assign err_frame   = r_err_frame;
  assign err_parity  = r_err_parity;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Two instances share clock and reset:
// dut_n runs 8N1, dut_p runs 8O1, both with one clock per oversample tick.
module tb_uart_rx;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rx_n, rx_p;
  logic       rd_en_n, rd_en_p;
  logic       err_clr_n, err_clr_p;
  logic [7:0] rd_data_n, rd_data_p;
  logic       rx_empty_n, rx_empty_p;
  logic       rx_full_n, rx_full_p;
  logic       err_frame_n, err_frame_p;
  logic       err_parity_n, err_parity_p;
  logic       err_overrun_n, err_overrun_p;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  bit seen;

  always #5 clk_in = ~clk_in;

  uart_rx #(.SYS_CLK_FREQ(1600), .BAUD_RATE(100), .PARITY_MODE(0), .FIFO_DEPTH(8)) dut_n (
    .clk_in(clk_in), .rst_in(rst_in), .rx(rx_n), .rd_en(rd_en_n), .rd_data(rd_data_n),
    .rx_empty(rx_empty_n), .rx_full(rx_full_n), .err_frame(err_frame_n),
    .err_parity(err_parity_n), .err_overrun(err_overrun_n), .err_clr(err_clr_n));

  uart_rx #(.SYS_CLK_FREQ(1600), .BAUD_RATE(100), .PARITY_MODE(1), .FIFO_DEPTH(8)) dut_p (
    .clk_in(clk_in), .rst_in(rst_in), .rx(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_p),
    .rx_empty(rx_empty_p), .rx_full(rx_full_p), .err_frame(err_frame_p),
    .err_parity(err_parity_p), .err_overrun(err_overrun_p), .err_clr(err_clr_p));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int sel, input logic v);
    if (sel == 0) rx_n = v;
    else          rx_p = v;
  endtask

  // Called at a negedge; each bit lasts 16 clocks. cnt counts rising edges
  // since the first bit was driven. rd_at raises dut_n rd_en so it is high
  // across rising edge rd_at+1.
  task automatic send_bits(input int sel, input logic [10:0] bits, input int nbits,
                           input int rd_at);
    int cnt = 0;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < nbits; i++) begin
      drive_line(sel, bits[i]);
      for (int j = 0; j < 16; j++) begin
        @(negedge clk_in);
        cnt++;
        if (sel == 0) begin
          if (cnt == rd_at)          rd_en_n = 1'b1;
          else if (cnt == rd_at + 1) rd_en_n = 1'b0;
          if (!seen && !rx_empty_n) begin
            seen = 1'b1;
            lat  = cnt;
          end
        end
      end
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic stop, input int rd_at);
    if (sel == 0) send_bits(0, {1'b1, stop, d, 1'b0}, 10, rd_at);
    else          send_bits(1, {stop, p, d, 1'b0}, 11, rd_at);
    drive_line(sel, 1'b1);
    repeat (16) @(negedge clk_in);
  endtask

  task automatic pop_n();
    rd_en_n = 1'b1;
    @(negedge clk_in);
    rd_en_n = 1'b0;
  endtask

  task automatic clr_n();
    err_clr_n = 1'b1;
    @(negedge clk_in);
    err_clr_n = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rx_n = 1'b1; rx_p = 1'b1;
    rd_en_n = 1'b0; rd_en_p = 1'b0;
    err_clr_n = 1'b0; err_clr_p = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset values
    check("rst_rd_data",  32'(rd_data_n),     32'h00);
    check("rst_empty",    32'(rx_empty_n),    32'h1);
    check("rst_full",     32'(rx_full_n),     32'h0);
    check("rst_frame",    32'(err_frame_n),   32'h0);
    check("rst_parity",   32'(err_parity_n),  32'h0);
    check("rst_overrun",  32'(err_overrun_n), 32'h0);
    repeat (8) @(negedge clk_in);

    // 8N1 0xA5: 2 sync + 152 ticks + 1 push cycle
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
    check("a5_latency",   32'(lat),           32'd155);
    check("a5_data",      32'(rd_data_n),     32'hA5);
    check("a5_frame",     32'(err_frame_n),   32'h0);
    check("a5_parity",    32'(err_parity_n),  32'h0);
    check("a5_overrun",   32'(err_overrun_n), 32'h0);
    pop_n();
    check("a5_popped",    32'(rx_empty_n),    32'h1);

    // 4-cycle glitch: rejected at start-bit centre, then a normal frame
    rx_n = 1'b0;
    repeat (4) @(negedge clk_in);
    rx_n = 1'b1;
    repeat (40) @(negedge clk_in);
    check("glitch_empty", 32'(rx_empty_n),    32'h1);
    check("glitch_frame", 32'(err_frame_n),   32'h0);
    send_frame(0, 8'h66, 1'b0, 1'b1, -1);
    check("after_glitch", 32'(rd_data_n),     32'h66);
    pop_n();

    // Stop bit low
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
    check("ferr_flag",    32'(err_frame_n),   32'h1);
    check("ferr_empty",   32'(rx_empty_n),    32'h1);
    clr_n();
    check("ferr_clr",     32'(err_frame_n),   32'h0);

    // Held-low break: one framing error only
    rx_n = 1'b0;
    repeat (200) @(negedge clk_in);
    check("break_flag",   32'(err_frame_n),   32'h1);
    clr_n();
    repeat (200) @(negedge clk_in);
    check("break_once",   32'(err_frame_n),   32'h0);
    rx_n = 1'b1;
    repeat (32) @(negedge clk_in);
    check("break_empty",  32'(rx_empty_n),    32'h1);

    // Odd parity, 0x01 has one set bit so the correct parity bit is 0
    send_frame(1, 8'h01, 1'b1, 1'b1, -1);
    check("perr_flag",    32'(err_parity_p),  32'h1);
    check("perr_empty",   32'(rx_empty_p),    32'h1);
    check("perr_frame",   32'(err_frame_p),   32'h0);
    err_clr_p = 1'b1;
    @(negedge clk_in);
    err_clr_p = 1'b0;
    check("perr_clr",     32'(err_parity_p),  32'h0);
    send_frame(1, 8'h01, 1'b0, 1'b1, -1);
    check("par_ok_empty", 32'(rx_empty_p),    32'h0);
    check("par_ok_data",  32'(rd_data_p),     32'h01);
    check("par_ok_flag",  32'(err_parity_p),  32'h0);

    // Nine bytes, no reads: ninth dropped with overrun
    for (int i = 0; i < 8; i++) send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b1, -1);
    check("fill_full",    32'(rx_full_n),     32'h1);
    check("fill_no_ovr",  32'(err_overrun_n), 32'h0);
    send_frame(0, 8'h99, 1'b0, 1'b1, -1);
    check("ovr_flag",     32'(err_overrun_n), 32'h1);
    check("ovr_full",     32'(rx_full_n),     32'h1);
    for (int i = 0; i < 8; i++) begin
      check("ovr_order",  32'(rd_data_n),     32'h10 + 32'(i));
      pop_n();
    end
    check("ovr_drained",  32'(rx_empty_n),    32'h1);
    clr_n();
    check("ovr_clr",      32'(err_overrun_n), 32'h0);

    // Full FIFO, ninth byte lands while rd_en pops the head on the push edge
    for (int i = 0; i < 8; i++) send_frame(0, 8'h20 + 8'(i), 1'b0, 1'b1, -1);
    send_frame(0, 8'h28, 1'b0, 1'b1, 154);
    check("pp_no_ovr",    32'(err_overrun_n), 32'h0);
    check("pp_full",      32'(rx_full_n),     32'h1);
    for (int i = 0; i < 8; i++) begin
      check("pp_order",   32'(rd_data_n),     32'h21 + 32'(i));
      pop_n();
    end
    check("pp_drained",   32'(rx_empty_n),    32'h1);

    // Reset in the middle of the data bits
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
    check("pre_rst_data", 32'(rd_data_n),     32'h5A);
    check("pre_rst_ferr", 32'(err_frame_n),   32'h1);
    send_bits(0, {1'b1, 1'b1, 8'h77, 1'b0}, 4, -1);
    rst_in = 1'b1;
    rx_n   = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    check("mid_rst_empty",   32'(rx_empty_n),    32'h1);
    check("mid_rst_full",    32'(rx_full_n),     32'h0);
    check("mid_rst_data",    32'(rd_data_n),     32'h00);
    check("mid_rst_frame",   32'(err_frame_n),   32'h0);
    check("mid_rst_parity",  32'(err_parity_n),  32'h0);
    check("mid_rst_overrun", 32'(err_overrun_n), 32'h0);
    repeat (40) @(negedge clk_in);
    send_frame(0, 8'hC3, 1'b0, 1'b1, -1);
    check("post_rst_latency", 32'(lat),          32'd155);
    check("post_rst_data",    32'(rd_data_n),    32'hC3);
    check("post_rst_frame",   32'(err_frame_n),  32'h0);
    pop_n();
    check("post_rst_empty",   32'(rx_empty_n),   32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
